tcb_lib_arbiter: RTL

TCB_LIB_ARBITER -- requirements
Module: tcb_lib_arbiter

---
 rtl/tcb_lib_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tcb_lib_arbiter.sv
// tcb_lib_arbiter: shares one TCB subordinate among MN managers.
// Grants are combinational. A stalled owner is held until its transfer
// completes, and a locked owner keeps exclusive access until it releases
// the lock. rsp_sel follows the select through the subordinate read delay.
module tcb_lib_arbiter #(
   parameter  int unsigned MN  = 2,
   localparam int unsigned ML  = (MN > 1) ? $clog2(MN) : 1,
   parameter  int unsigned DLY = 1,
   parameter  int unsigned RR  = 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [MN-1:0] req,
   input  logic [MN-1:0] lck,
   input  logic          rdy,
   output logic [MN-1:0] gnt,
   output logic [ML-1:0] sel,
   output logic [ML-1:0] rsp_sel
);

   logic [ML-1:0] ptr_q, ptr_d;
   logic [ML-1:0] own_q, own_d;
   logic          hold_q, hold_d;
   logic          lock_q, lock_d;

   logic [ML-1:0] arb_idx;
   logic          arb_vld;
   logic [ML-1:0] gnt_idx;
   logic          gnt_vld;
   logic          trf;

   // Free arbitration: fixed priority from index 0, or round-robin from ptr_q.
   always_comb begin
      int unsigned   j;
      logic [ML-1:0] idx;
      j       = 0;
      idx     = '0;
      arb_vld = 1'b0;
      arb_idx = '0;
      for (int unsigned i = 0; i < MN; i++) begin
         j   = (RR != 0) ? (32'(ptr_q) + i) % MN : i;
         idx = ML'(j);
         if (!arb_vld && req[idx]) begin
            arb_vld = 1'b1;
            arb_idx = idx;
         end
      end
   end

   // Grant selection: lock beats hold beats free arbitration; reset masks all.
   always_comb begin
      gnt_idx = arb_idx;
      gnt_vld = arb_vld;
      if (lock_q) begin
         // A locked but idle owner still blocks everyone else.
         gnt_idx = own_q;
         gnt_vld = req[own_q];
      end else if (hold_q && req[own_q]) begin
         gnt_idx = own_q;
         gnt_vld = 1'b1;
      end
      if (rst) begin
         gnt_vld = 1'b0;
      end
      gnt = '0;
      if (gnt_vld) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   assign sel = gnt_vld ? gnt_idx : own_q;
   assign trf = |(gnt & req) & rdy;

   // Next state for pointer, owner, hold and lock.
   always_comb begin
      ptr_d  = ptr_q;
      own_d  = own_q;
      lock_d = lock_q;
      // Hold only survives a cycle where the owner is granted but stalled.
      hold_d = gnt_vld & ~rdy;
      if (gnt_vld) begin
         own_d = gnt_idx;
      end
      if (trf) begin
         lock_d = lck[gnt_idx];
         if (RR != 0) begin
            ptr_d = (32'(gnt_idx) == MN - 1) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= '0;
         own_q  <= '0;
         hold_q <= 1'b0;
         lock_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         own_q  <= own_d;
         hold_q <= hold_d;
         lock_q <= lock_d;
      end
   end

   if (DLY == 0) begin : g_nodly
      assign rsp_sel = sel;
   end else begin : g_dly
      logic [ML-1:0] rsp_q [DLY];

      // Stage 0 captures the select of each transfer; later stages age it.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int unsigned i = 0; i < DLY; i++) begin
               rsp_q[i] <= '0;
            end
         end else begin
            if (trf) begin
               rsp_q[0] <= sel;
            end
            for (int unsigned i = 1; i < DLY; i++) begin
               rsp_q[i] <= rsp_q[i-1];
            end
         end
      end

      assign rsp_sel = rsp_q[DLY-1];
   end

endmodule
